led_cube_uart_tx: RTL

// - Transmit-side Avalon-MM master for the Altera UART core; counterpart of the cube's UART receive poller.
// - Buffers bytes from cube logic (status/echo/telemetry) in a FIFO.
// - Polls UART STATUS until TRDY=1, then writes each byte to TXDATA.
// - Sits beside the receive poller on a separate Avalon master port into the same UART slave.

---
 rtl/led_cube_uart_pkg.sv | 25 ++
 rtl/led_cube_tx_fifo.sv | 59 +++++
 rtl/led_cube_uart_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/led_cube_uart_pkg.sv
// Shared constants and types for the LED cube UART transmit path.
// Register offsets and STATUS bit positions follow the Altera UART core map.
package led_cube_uart_pkg;

   localparam logic [4:0] UART_RXDATA_ADDR  = 5'h00;
   localparam logic [4:0] UART_TXDATA_ADDR  = 5'h04;
   localparam logic [4:0] UART_STATUS_ADDR  = 5'h08;
   localparam logic [4:0] UART_CONTROL_ADDR = 5'h0C;

   localparam int STATUS_TMT_BIT  = 5;
   localparam int STATUS_TRDY_BIT = 6;
   localparam int STATUS_RRDY_BIT = 7;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      POLL     = 2'd1,
      WAIT_RDV = 2'd2,
      WRITE    = 2'd3
   } tx_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/led_cube_tx_fifo.sv
// Synchronous byte FIFO; data_out shows the head combinationally so the
// writer can present it on the bus without an extra read cycle.
module led_cube_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           data_in,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == (PTR_W+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign data_out = mem[rd_ptr_q];

   // Push while full is dropped here, so a simultaneous pop cannot admit it.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) count_d = count_q + (PTR_W+1)'(1);
      if (do_pop && !do_push) count_d = count_q - (PTR_W+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= data_in;
   end

endmodule

// File: rtl/led_cube_uart_tx.sv
// Avalon-MM master that drains a byte FIFO into the UART TXDATA register,
// polling STATUS.TRDY before each write and dropping bytes that time out.
module led_cube_uart_tx
   import led_cube_uart_pkg::*;
#(
   parameter int         FIFO_DEPTH  = 16,
   parameter logic [4:0] STATUS_ADDR = UART_STATUS_ADDR,
   parameter logic [4:0] TXDATA_ADDR = UART_TXDATA_ADDR,
   parameter int         POLL_LIMIT  = 1023
) (
   input  logic        clock_sink_clk,
   input  logic        reset_sink_reset,
   output logic [4:0]  avalon_master_address,
   output logic        avalon_master_read,
   input  logic [15:0] avalon_master_readdata,
   input  logic        avalon_master_readdatavalid,
   input  logic        avalon_master_waitrequest,
   output logic        avalon_master_write,
   output logic [15:0] avalon_master_writedata,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        tx_busy,
   output logic [7:0]  tx_sent_count,
   output logic [7:0]  tx_drop_count
);

   localparam int POLL_W = $clog2(POLL_LIMIT + 1);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_LIMIT);

   tx_state_t         state_q, state_d;
   logic [POLL_W-1:0] poll_q, poll_d;
   logic [7:0]        sent_q, sent_d;
   logic [7:0]        drop_q, drop_d;
   logic              fifo_pop, fifo_full, fifo_empty;
   logic [7:0]        fifo_head;
   logic [CNT_W-1:0]  fifo_count_unused;
   logic              rdata_unused;

   assign rdata_unused = ^{avalon_master_readdata[15:STATUS_TRDY_BIT+1],
                           avalon_master_readdata[STATUS_TRDY_BIT-1:0]};

   led_cube_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk      (clock_sink_clk),
      .rst_n    (reset_sink_reset),
      .push     (tx_valid),
      .pop      (fifo_pop),
      .data_in  (tx_data),
      .data_out (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count_unused)
   );

   assign tx_ready      = !fifo_full;
   assign tx_busy       = !fifo_empty || (state_q != IDLE);
   assign tx_sent_count = sent_q;
   assign tx_drop_count = drop_q;

   always_comb begin
      state_d                 = state_q;
      poll_d                  = poll_q;
      sent_d                  = sent_q;
      drop_d                  = drop_q;
      fifo_pop                = 1'b0;
      avalon_master_read      = 1'b0;
      avalon_master_write     = 1'b0;
      avalon_master_address   = 5'h00;
      avalon_master_writedata = 16'h0000;
      unique case (state_q)
         IDLE: begin
            // Bus address stays 0 while there is nothing to send.
            if (!fifo_empty) begin
               avalon_master_address = STATUS_ADDR;
               state_d               = POLL;
            end
         end
         POLL: begin
            avalon_master_read    = 1'b1;
            avalon_master_address = STATUS_ADDR;
            if (!avalon_master_waitrequest) state_d = WAIT_RDV;
         end
         WAIT_RDV: begin
            avalon_master_address = STATUS_ADDR;
            if (avalon_master_readdatavalid) begin
               if (avalon_master_readdata[STATUS_TRDY_BIT]) begin
                  poll_d  = '0;
                  state_d = WRITE;
               end else if (poll_q < POLL_MAX) begin
                  poll_d  = poll_q + POLL_W'(1);
                  state_d = POLL;
               end else begin
                  fifo_pop = 1'b1;
                  drop_d   = sat_inc8(drop_q);
                  poll_d   = '0;
                  state_d  = IDLE;
               end
            end
         end
         WRITE: begin
            avalon_master_write     = 1'b1;
            avalon_master_address   = TXDATA_ADDR;
            avalon_master_writedata = {8'h00, fifo_head};
            if (!avalon_master_waitrequest) begin
               fifo_pop = 1'b1;
               sent_d   = sent_q + 8'd1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_sink_clk or negedge reset_sink_reset) begin
      if (!reset_sink_reset) begin
         state_q <= IDLE;
         poll_q  <= '0;
         sent_q  <= 8'h00;
         drop_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         poll_q  <= poll_d;
         sent_q  <= sent_d;
         drop_q  <= drop_d;
      end
   end

endmodule
